// File: rtl/srt_div_pkg.sv
// Shared types, limits and operand-slicing helper for the srt_div_arbiter slice.
// Optional feature macro used by the top: SRT_DIV_ZERO_BYPASS_EN.
package srt_div_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int MAX_DW     = 64;
    localparam int MAX_NREQ   = 8;
    localparam int BUS_W      = MAX_DW * MAX_NREQ;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Slice idx of a packed per-requester bus (zero-extended to BUS_W); caller truncates to dw.
    function automatic logic [MAX_DW-1:0] op_slice(
        input logic [BUS_W-1:0] bus,
        input int unsigned      idx,
        input int unsigned      dw
    );
        return MAX_DW'(bus >> (idx * dw));
    endfunction

endpackage

// File: rtl/srt_rr_arbiter.sv
// Round-robin grant for the shared divider: combinational rotate-priority search
// starting at a registered pointer that the owning FSM reloads after each response.
module srt_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic                    ptr_load,
    input  logic [$clog2(NREQ)-1:0] ptr_value,
    output logic                    grant_valid,
    output logic [$clog2(NREQ)-1:0] grant_idx
);

    localparam int IW = $clog2(NREQ);
    localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

    logic [IW-1:0] ptr_r;
    logic [IW:0]   sum_s;
    logic [IW-1:0] cand_s;
    logic          hit_s;

    // Rotate-priority search: first valid requester at or above the pointer, wrapping to 0.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = {IW{1'b0}};
        sum_s       = {(IW+1){1'b0}};
        cand_s      = {IW{1'b0}};
        hit_s       = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s       = {1'b0, ptr_r} + (IW+1)'(k);
            cand_s      = (sum_s >= NREQ_W) ? IW'(sum_s - NREQ_W) : IW'(sum_s);
            hit_s       = req_valid[cand_s] & ~grant_valid;
            grant_idx   = hit_s ? cand_s : grant_idx;
            grant_valid = grant_valid | hit_s;
        end
    end

    // Pointer moves only when the FSM hands over the slot after a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {IW{1'b0}};
        end else if (ptr_load) begin
            ptr_r <= ptr_value;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/srt_div_arbiter.sv
// Shares one srt_4_div among NREQ requesters: round-robin accept, start/finish sequencing,
// one-cycle response pulse to the owner. Optional macro SRT_DIV_ZERO_BYPASS_EN skips the divider on /0.
module srt_div_arbiter
    import srt_div_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0] req_dividend,
    input  logic [NREQ*DW-1:0] req_divisor,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_quotient,
    output logic [DW-1:0]     rsp_remainder,
    output logic              rsp_error,
    output logic              busy,
    output logic              div_rst_n,
    output logic              div_start,
    output logic [DW-1:0]     div_dividend,
    output logic [DW-1:0]     div_divisor,
    input  logic [DW-1:0]     div_quotient,
    input  logic [DW-1:0]     div_remainder,
    input  logic              div_finish,
    input  logic              div_error
);

    localparam int IW = $clog2(NREQ);

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        return {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_e          state_r;
    logic [IW-1:0]   owner_r;
    logic            busy_r;
    logic            div_start_r;
    logic [NREQ-1:0] rsp_valid_r;
    logic [DW-1:0]   div_dividend_r;
    logic [DW-1:0]   div_divisor_r;
    logic [DW-1:0]   rsp_quotient_r;
    logic [DW-1:0]   rsp_remainder_r;
    logic            rsp_error_r;

    logic            grant_valid_s;
    logic [IW-1:0]   grant_idx_s;
    logic            ptr_load_s;
    logic [IW-1:0]   ptr_next_s;
    logic [DW-1:0]   sel_dividend_s;
    logic [DW-1:0]   sel_divisor_s;

    srt_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .ptr_load    (ptr_load_s),
        .ptr_value   (ptr_next_s),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    assign sel_dividend_s = DW'(op_slice(BUS_W'(req_dividend), 32'(grant_idx_s), DW));
    assign sel_divisor_s  = DW'(op_slice(BUS_W'(req_divisor), 32'(grant_idx_s), DW));

    // After a response the search restarts just past the requester that was served.
    always_comb begin
        ptr_load_s = (state_r == RESP);
        if (owner_r == IW'(NREQ - 1)) begin
            ptr_next_s = {IW{1'b0}};
        end else begin
            ptr_next_s = owner_r + IW'(1);
        end
    end

    // Accept is combinational so the requester sees it in the grant cycle; never during reset.
    always_comb begin
        if (!rst && (state_r == IDLE) && grant_valid_s) begin
            req_ready = onehot(grant_idx_s);
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Main sequencer: accept, single-cycle start, wait for finish, one-cycle response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            owner_r         <= {IW{1'b0}};
            busy_r          <= 1'b0;
            div_start_r     <= 1'b0;
            rsp_valid_r     <= {NREQ{1'b0}};
            div_dividend_r  <= {DW{1'b0}};
            div_divisor_r   <= {DW{1'b0}};
            rsp_quotient_r  <= {DW{1'b0}};
            rsp_remainder_r <= {DW{1'b0}};
            rsp_error_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    div_start_r <= 1'b0;
                    rsp_valid_r <= {NREQ{1'b0}};
                    if (grant_valid_s) begin
                        div_dividend_r <= sel_dividend_s;
                        div_divisor_r  <= sel_divisor_s;
                        owner_r        <= grant_idx_s;
                        busy_r         <= 1'b1;
`ifdef SRT_DIV_ZERO_BYPASS_EN
                        if (sel_divisor_s == {DW{1'b0}}) begin
                            rsp_quotient_r  <= {DW{1'b1}};
                            rsp_remainder_r <= sel_dividend_s;
                            rsp_error_r     <= 1'b1;
                            rsp_valid_r     <= onehot(grant_idx_s);
                            state_r         <= RESP;
                        end else begin
                            div_start_r <= 1'b1;
                            state_r     <= ISSUE;
                        end
`else
                        div_start_r <= 1'b1;
                        state_r     <= ISSUE;
`endif
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    // A finish seen while start is still high belongs to no operation of ours.
                    div_start_r <= 1'b0;
                    state_r     <= WAIT;
                end
                WAIT: begin
                    if (div_finish) begin
                        rsp_quotient_r  <= div_quotient;
                        rsp_remainder_r <= div_remainder;
                        rsp_error_r     <= div_error;
                        rsp_valid_r     <= onehot(owner_r);
                        state_r         <= RESP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                RESP: begin
                    rsp_valid_r <= {NREQ{1'b0}};
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    div_start_r <= 1'b0;
                    rsp_valid_r <= {NREQ{1'b0}};
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign div_rst_n     = ~rst;
    assign div_start     = div_start_r;
    assign div_dividend  = div_dividend_r;
    assign div_divisor   = div_divisor_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_quotient  = rsp_quotient_r;
    assign rsp_remainder = rsp_remainder_r;
    assign rsp_error     = rsp_error_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_srt_div_arbiter.sv
// Directed bench for srt_div_arbiter with a behavioural stand-in for the shared divider.
// Expectations follow the default build unless SRT_DIV_ZERO_BYPASS_EN is defined.
module tb_srt_div_arbiter;

    localparam int DW   = 32;
    localparam int NREQ = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready, rsp_valid;
    logic [NREQ*DW-1:0]  req_dividend = '0, req_divisor = '0;
    logic [DW-1:0]       rsp_quotient, rsp_remainder, div_dividend, div_divisor;
    logic [DW-1:0]       div_quotient, div_remainder;
    logic                rsp_error, busy, div_rst_n, div_start, div_finish, div_error;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    logic [NREQ-1:0] acc_mask = '0;

    // divider model controls
    int          div_lat = 2;
    int          m_cnt;
    logic [DW-1:0] m_a, m_b;
    logic        model_finish;
    logic        spur_finish = 1'b0;

    always #5 clk = ~clk;

    srt_div_arbiter #(.DW(DW), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
        .rsp_remainder(rsp_remainder), .rsp_error(rsp_error),
        .busy(busy), .div_rst_n(div_rst_n), .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_finish(div_finish), .div_error(div_error)
    );

    assign div_finish = model_finish | spur_finish;

    // Divider stand-in: latches operands on start, finishes div_lat cycles later.
    always @(posedge clk) begin
        if (!div_rst_n) begin
            m_cnt <= 0;
            model_finish <= 1'b0;
            div_quotient <= '0;
            div_remainder <= '0;
            div_error <= 1'b0;
        end else begin
            model_finish <= 1'b0;
            if (div_start) begin
                m_a <= div_dividend;
                m_b <= div_divisor;
                m_cnt <= div_lat;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    model_finish <= 1'b1;
                    if (m_b == 0) begin
                        div_quotient <= '1;
                        div_remainder <= m_a;
                        div_error <= 1'b1;
                    end else begin
                        div_quotient <= m_a / m_b;
                        div_remainder <= m_a % m_b;
                        div_error <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        req_valid = req_valid & ~acc_mask;
        #1;
        cyc++;
        acc_mask = req_ready;
    endtask

    task automatic resample();
        #1;
        acc_mask = req_ready;
    endtask

    task automatic set_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_dividend[idx*DW +: DW] = a;
        req_divisor[idx*DW +: DW] = b;
        req_valid[idx] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        acc_mask = '0;
        div_lat = 2;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            step();
            if (rsp_valid != '0) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '1;
        req_dividend = '1;
        req_divisor = '1;
        step();
        step();
        tests_run++;
        if ({req_ready, rsp_valid, busy, div_start, div_rst_n} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got ready=%b rsp=%b busy=%b start=%b rst_n=%b expected all 0",
                     req_ready, rsp_valid, busy, div_start, div_rst_n);
        end
        tests_run++;
        if ({div_dividend, div_divisor, rsp_quotient, rsp_remainder, rsp_error} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got dd=%h dv=%h q=%h r=%h e=%b expected 0",
                     div_dividend, div_divisor, rsp_quotient, rsp_remainder, rsp_error);
        end
        req_valid = '0;
        req_dividend = '0;
        req_divisor = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (div_rst_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: got div_rst_n=%b expected 1", div_rst_n);
        end
    endtask

    task automatic test_single();
        int t_acc, fin, rsp, starts;
        do_reset();
        step();
        set_req(1, 32'h64, 32'h7);
        resample();
        t_acc = cyc;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL single_ready: got %b expected 0010", req_ready);
        end
        step();
        tests_run++;
        if ({div_start, busy, req_ready, div_dividend, div_divisor} !== {1'b1, 1'b1, 4'b0000, 32'h64, 32'h7}) begin
            tests_failed++;
            $display("FAIL single_issue: got start=%b busy=%b ready=%b dd=%h dv=%h expected 1 1 0000 64 7",
                     div_start, busy, req_ready, div_dividend, div_divisor);
        end
        fin = -1; rsp = -1; starts = 0;
        for (int i = 0; i < 30 && rsp < 0; i++) begin
            step();
            if (div_start) starts++;
            if (model_finish && fin < 0) fin = cyc;
            if (rsp_valid != '0) rsp = cyc;
        end
        tests_run++;
        if (starts != 0 || rsp != fin + 1 || fin < t_acc + 2) begin
            tests_failed++;
            $display("FAIL single_timing: got starts=%0d fin=%0d rsp=%0d (acc %0d) expected 0 starts, rsp=fin+1",
                     starts, fin, rsp, t_acc);
        end
        tests_run++;
        if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_error} !== {4'b0010, 32'hE, 32'h2, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_result: got v=%b q=%h r=%h e=%b expected 0010 e 2 0",
                     rsp_valid, rsp_quotient, rsp_remainder, rsp_error);
        end
        step();
        tests_run++;
        if ({rsp_valid, busy, rsp_quotient} !== {4'b0000, 1'b0, 32'hE}) begin
            tests_failed++;
            $display("FAIL single_after: got v=%b busy=%b q=%h expected 0000 0 e", rsp_valid, busy, rsp_quotient);
        end
    endtask

    task automatic test_all_four();
        logic [DW-1:0] a[4] = '{32'd100, 32'd200, 32'd300, 32'd400};
        logic [DW-1:0] b[4] = '{32'd3, 32'd7, 32'd11, 32'd13};
        logic [DW-1:0] eq[4] = '{32'd33, 32'd28, 32'd27, 32'd30};
        logic [DW-1:0] er[4] = '{32'd1, 32'd4, 32'd3, 32'd10};
        bit got;
        do_reset();
        step();
        for (int i = 0; i < NREQ; i++) set_req(i, a[i], b[i]);
        resample();
        for (int k = 0; k < NREQ; k++) begin
            wait_rsp(40, got);
            tests_run++;
            if (!got || {rsp_valid, rsp_quotient, rsp_remainder} !== {4'b0001 << k, eq[k], er[k]}) begin
                tests_failed++;
                $display("FAIL all_four_%0d: got v=%b q=%0d r=%0d expected v=%b q=%0d r=%0d",
                         k, rsp_valid, rsp_quotient, rsp_remainder, 4'b0001 << k, eq[k], er[k]);
            end
        end
    endtask

    task automatic test_rr_wrap();
        bit got;
        do_reset();
        step();
        set_req(0, 32'd9, 32'd2);
        resample();
        wait_rsp(40, got);
        tests_run++;
        if (!got || {rsp_valid, rsp_quotient, rsp_remainder} !== {4'b0001, 32'd4, 32'd1}) begin
            tests_failed++;
            $display("FAIL rr_first: got v=%b q=%0d r=%0d expected 0001 4 1", rsp_valid, rsp_quotient, rsp_remainder);
        end
        step();
        set_req(0, 32'd50, 32'd5);
        set_req(3, 32'd77, 32'd10);
        resample();
        tests_run++;
        if (req_ready !== 4'b1000) begin
            tests_failed++;
            $display("FAIL rr_wrap_grant: got %b expected 1000", req_ready);
        end
        wait_rsp(40, got);
        tests_run++;
        if (!got || {rsp_valid, rsp_quotient, rsp_remainder} !== {4'b1000, 32'd7, 32'd7}) begin
            tests_failed++;
            $display("FAIL rr_wrap_3: got v=%b q=%0d r=%0d expected 1000 7 7", rsp_valid, rsp_quotient, rsp_remainder);
        end
        wait_rsp(40, got);
        tests_run++;
        if (!got || {rsp_valid, rsp_quotient, rsp_remainder} !== {4'b0001, 32'd10, 32'd0}) begin
            tests_failed++;
            $display("FAIL rr_wrap_0: got v=%b q=%0d r=%0d expected 0001 10 0", rsp_valid, rsp_quotient, rsp_remainder);
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        int busy_ready;
        do_reset();
        step();
        set_req(1, 32'd45, 32'd6);
        set_req(2, 32'd19, 32'd4);
        resample();
        busy_ready = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (busy && req_ready != '0) busy_ready++;
            if (rsp_valid != '0) got = 1'b1;
        end
        tests_run++;
        if (!got || busy_ready != 0 || {rsp_valid, rsp_quotient, rsp_remainder} !== {4'b0010, 32'd7, 32'd3}) begin
            tests_failed++;
            $display("FAIL b2b_first: got v=%b q=%0d r=%0d busy_ready=%0d expected 0010 7 3 0",
                     rsp_valid, rsp_quotient, rsp_remainder, busy_ready);
        end
        step();
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL b2b_next_accept: got %b expected 0100 one cycle after response", req_ready);
        end
        wait_rsp(40, got);
        tests_run++;
        if (!got || {rsp_valid, rsp_quotient, rsp_remainder} !== {4'b0100, 32'd4, 32'd3}) begin
            tests_failed++;
            $display("FAIL b2b_second: got v=%b q=%0d r=%0d expected 0100 4 3", rsp_valid, rsp_quotient, rsp_remainder);
        end
    endtask

    task automatic test_div_zero();
        int t_acc, rsp, starts;
        do_reset();
        step();
        set_req(2, 32'h1234, 32'h0);
        resample();
        t_acc = cyc;
        rsp = -1; starts = 0;
        for (int i = 0; i < 30 && rsp < 0; i++) begin
            step();
            if (div_start) starts++;
            if (rsp_valid != '0) rsp = cyc;
        end
        tests_run++;
        if ({rsp_valid, rsp_error, rsp_quotient, rsp_remainder} !== {4'b0100, 1'b1, 32'hFFFF_FFFF, 32'h1234}) begin
            tests_failed++;
            $display("FAIL div_zero_result: got v=%b e=%b q=%h r=%h expected 0100 1 ffffffff 1234",
                     rsp_valid, rsp_error, rsp_quotient, rsp_remainder);
        end
`ifdef SRT_DIV_ZERO_BYPASS_EN
        tests_run++;
        if (rsp != t_acc + 1 || starts != 0) begin
            tests_failed++;
            $display("FAIL div_zero_bypass: got rsp=%0d starts=%0d expected rsp=%0d starts=0", rsp, starts, t_acc + 1);
        end
`else
        tests_run++;
        if (starts != 1 || rsp < t_acc + 3) begin
            tests_failed++;
            $display("FAIL div_zero_path: got starts=%0d rsp=%0d expected 1 start, rsp>=%0d", starts, rsp, t_acc + 3);
        end
`endif
    endtask

    task automatic test_spurious_finish();
        int fin, rsp, pulses;
        do_reset();
        step();
        spur_finish = 1'b1;
        step();
        spur_finish = 1'b0;
        step();
        tests_run++;
        if ({rsp_valid, busy} !== {4'b0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL spur_idle: got v=%b busy=%b expected 0000 0", rsp_valid, busy);
        end
        div_lat = 3;
        set_req(0, 32'd81, 32'd9);
        resample();
        step();
        spur_finish = 1'b1;
        step();
        spur_finish = 1'b0;
        fin = -1; rsp = -1; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (model_finish && fin < 0) fin = cyc;
            if (rsp_valid != '0) begin
                pulses++;
                if (rsp < 0) rsp = cyc;
            end
        end
        tests_run++;
        if (pulses != 1 || rsp != fin + 1 || {rsp_quotient, rsp_remainder} !== {32'd9, 32'd0}) begin
            tests_failed++;
            $display("FAIL spur_issue: got pulses=%0d fin=%0d rsp=%0d q=%0d r=%0d expected 1 pulse at fin+1, 9 0",
                     pulses, fin, rsp, rsp_quotient, rsp_remainder);
        end
    endtask

    task automatic test_reset_wait();
        int pulses;
        bit got;
        do_reset();
        div_lat = 10;
        step();
        set_req(3, 32'd1000, 32'd7);
        resample();
        step();
        step();
        tests_run++;
        if ({busy, div_start} !== 2'b10) begin
            tests_failed++;
            $display("FAIL rst_wait_pre: got busy=%b start=%b expected 1 0", busy, div_start);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (div_rst_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_wait_divrst: got %b expected 0", div_rst_n);
        end
        step();
        tests_run++;
        if ({busy, rsp_valid, div_rst_n} !== {1'b0, 4'b0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL rst_wait_idle: got busy=%b v=%b rst_n=%b expected 0 0000 0", busy, rsp_valid, div_rst_n);
        end
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (rsp_valid != '0) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL rst_wait_norsp: got %0d pulses expected 0", pulses);
        end
        div_lat = 2;
        set_req(0, 32'd10, 32'd3);
        resample();
        wait_rsp(40, got);
        tests_run++;
        if (!got || {rsp_valid, rsp_quotient, rsp_remainder, rsp_error} !== {4'b0001, 32'd3, 32'd1, 1'b0}) begin
            tests_failed++;
            $display("FAIL rst_wait_fresh: got v=%b q=%0d r=%0d e=%b expected 0001 3 1 0",
                     rsp_valid, rsp_quotient, rsp_remainder, rsp_error);
        end
    endtask

    task automatic test_soak();
        logic [DW-1:0] sa[NREQ], sb[NREQ];
        bit outstanding[NREQ];
        int waits[NREQ];
        int accepts, rsps, idx, g;
        do_reset();
        accepts = 0; rsps = 0;
        for (int i = 0; i < NREQ; i++) begin
            outstanding[i] = 1'b0;
            waits[i] = 0;
        end
        for (int c = 0; c < 20000 && rsps < 1000; c++) begin
            step();
            if (rsp_valid != '0) begin
                rsps++;
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) idx = i;
                tests_run++;
                if (!$onehot(rsp_valid) || !outstanding[idx] || rsp_error !== 1'b0 ||
                    rsp_quotient !== sa[idx] / sb[idx] || rsp_remainder !== sa[idx] % sb[idx]) begin
                    tests_failed++;
                    $display("FAIL soak_rsp: got v=%b q=%h r=%h e=%b expected owner %0d q=%h r=%h",
                             rsp_valid, rsp_quotient, rsp_remainder, rsp_error, idx,
                             sa[idx] / sb[idx], sa[idx] % sb[idx]);
                end
                outstanding[idx] = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!outstanding[i] && !req_valid[i] && $urandom_range(0, 1) == 1) begin
                    sa[i] = $urandom >> $urandom_range(0, 31);
                    sb[i] = $urandom >> $urandom_range(4, 31);
                    if (sb[i] == 0) sb[i] = 32'd1;
                    set_req(i, sa[i], sb[i]);
                    outstanding[i] = 1'b1;
                end
            end
            div_lat = $urandom_range(1, 4);
            resample();
            if (req_ready != '0) begin
                accepts++;
                g = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                tests_run++;
                if (waits[g] > NREQ - 1) begin
                    tests_failed++;
                    $display("FAIL soak_starve: got requester %0d waited %0d ops expected <= %0d", g, waits[g], NREQ - 1);
                end
                waits[g] = 0;
                for (int i = 0; i < NREQ; i++) if (i != g && req_valid[i]) waits[i]++;
            end
        end
        tests_run++;
        if (rsps != 1000 || accepts != rsps) begin
            tests_failed++;
            $display("FAIL soak_count: got rsps=%0d accepts=%0d expected 1000 each", rsps, accepts);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_rr_wrap();
        test_back_to_back();
        test_div_zero();
        test_spurious_finish();
        test_reset_wait();
        test_soak();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/srt_div_arbiter.md
Name: srt_div_arbiter

Overview:
Shares one srt_4_div instance among NREQ requesters.
- Arbitrates requests round-robin and latches the winner's operands.
- Sequences the divider's start/finish handshake.
- Returns quotient, remainder and error to the owning requester with a one-cycle response pulse.
- Sits between client units and the divider. It is the only block driving the divider's start and operand inputs.

Parameters:
DW, 32, operand/result width (must match divider)
NREQ, 4, number of requesters (2..8)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request; held until accepted
req_ready  out  NREQ  one-hot accept, combinational, IDLE only
req_dividend  in  NREQ*DW  packed dividends, slice i = requester i
req_divisor  in  NREQ*DW  packed divisors
rsp_valid  out  NREQ  one-hot, one-cycle result pulse to owner
rsp_quotient  out  DW  shared result bus
rsp_remainder  out  DW  shared result bus
rsp_error  out  1  divide-by-zero flag for the response
busy  out  1  high in any state other than IDLE
div_rst_n  out  1  divider reset, equals ~rst
div_start  out  1  divider start
div_dividend  out  DW  latched operand to divider
div_divisor  out  DW  latched operand to divider
div_quotient  in  DW  divider result
div_remainder  in  DW  divider result (divider port name: reminder)
div_finish  in  1  divider done
div_error  in  1  divider divide-by-zero

Behaviour:
- Reset (sync): state=IDLE, rr pointer=0, owner=0, all outputs 0 except div_rst_n=0 while rst is high. Operand and result registers are cleared to 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant the first requester with req_valid set, searching from pointer upward with wrap (NREQ-1 -> 0).
  - req_ready[g]=1 in the same cycle. Latch its operands into div_dividend/div_divisor and owner=g, then go to ISSUE.
  - No valid request: stay in IDLE, req_ready=0.
- ISSUE: div_start=1 for exactly this cycle, then go to WAIT. A div_finish seen in ISSUE is ignored.
- WAIT:
  - Hold div_start=0 and operands stable.
  - On div_finish=1, capture div_quotient, div_remainder and div_error into rsp registers, then go to RESP.
  - There is no timeout.
- RESP:
  - rsp_valid[owner]=1 for one cycle; pointer=(owner+1) mod NREQ; go to IDLE.
  - rsp_quotient, rsp_remainder and rsp_error hold their value until the next capture.
- Latency: acceptance at cycle T; start at T+1; finish at F≥T+2; rsp_valid at F+1. The earliest next accept is F+2.
- div_finish outside WAIT is ignored. New req_valid outside IDLE is not accepted (req_ready=0). A requester may not drop req_valid or change operands before req_ready.
- Reset mid-operation returns to IDLE with no response issued. The divider is reset through div_rst_n in the same cycle.
- Fairness: a requester that holds req_valid waits at most NREQ-1 other operations.

Optional Feature:
SRT_DIV_ZERO_BYPASS_EN
- Defined: a zero divisor is detected at accept.
  - The FSM goes IDLE->RESP directly and skips the divider (div_start stays 0).
  - Response: rsp_error=1, rsp_quotient='1, rsp_remainder=dividend.
  - rsp_valid arrives at T+1.
- Undefined: zero-divisor requests go through the divider like any other operation. rsp_error=div_error, and quotient/remainder are whatever the divider returns.

Decomposition:
- Package srt_div_pkg holds:
  - the DW default;
  - the state typedef enum {IDLE, ISSUE, WAIT, RESP};
  - a function to extract operand slice i from a packed bus.
- One sub-module, srt_rr_arbiter (parameter NREQ), contains:
  - combinational rotate-priority grant from req_valid and pointer;
  - grant_valid and grant_idx outputs;
  - a pointer update input driven by the FSM in RESP.

Test Plan:
- Single request: requester 1 sends 0x64/0x7 -> req_ready[1] at T, div_start at T+1 only, rsp_valid[1] one cycle after div_finish, quotient 0xE, remainder 0x2, error 0.
- All four request simultaneously after reset: operands 100/3, 200/7, 300/11, 400/13 -> served in order 0,1,2,3, returning (33,1), (28,4), (27,3), (30,10).
- Round-robin wrap: requester 0 is served, then requesters 0 and 3 request together -> 3 is served before 0.
- Divide by zero, 0x1234/0 -> rsp_error=1. With SRT_DIV_ZERO_BYPASS_EN: quotient 0xFFFFFFFF, remainder 0x1234, rsp_valid at T+1, no div_start.
- Reset asserted in WAIT -> next cycle state=IDLE, div_rst_n=0, no rsp_valid. After release, a fresh 10/3 returns (3,1).
- Random soak, 1000 operations: random NREQ-way valids and shifted random operands -> every response matches / and %; no request starves; exactly one rsp_valid per accept.
